// File: rtl/prog_clk_div.sv
// Purpose: runtime-programmable integer clock divider, 50% duty for even and odd N (2..2^W-1).
// Latency: en sampled at posedge k starts a period; q_p/tick high after k, odd-N clk_out rises at negedge k.
// Backpressure: none; dropping en lets the running period finish, so clk_out never shows a runt pulse.
//
// Ports:
//   clk      source clock; posedge drives the period counter, negedge only feeds q_n
//   rst_n    asynchronous active-low reset; the only event allowed to truncate a period
//   en       level-sensitive run request
//   div_i    requested divisor; 0 and 1 are clamped to 2, sampled only at period boundaries
//   clk_out  divided clock
//   tick     one source-cycle pulse in the cycle a clk_out period starts
//   busy     a period is in progress (counter non-zero or high phase still registered)
//   n_act    divisor currently in effect
module prog_clk_div #(
   parameter int W         = 8,
   parameter int RESET_DIV = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] div_i,
   output logic         clk_out,
   output logic         tick,
   output logic         busy,
   output logic [W-1:0] n_act
);

   // Position within the current period; 0 means "at a boundary".
   logic [W-1:0] cnt;
   // High-phase flag from the posedge domain and its half-cycle-delayed copy.
   logic         q_p;
   logic         q_n;

   logic         adv;
   logic         at_wrap;
   logic         load_n;
   logic [W-1:0] div_clamped;
   logic [W:0]   half;

   // Keep counting while a period is unfinished even if en has dropped,
   // which is what makes disabling glitch-free.
   assign adv     = en | (cnt != '0);
   assign at_wrap = (cnt == (n_act - W'(1)));

   // Two boundaries accept a new divisor: the last cycle of a running period,
   // and any idle edge (adv low implies cnt == 0 and en == 0).
   assign load_n  = (adv & at_wrap) | ~adv;

   assign div_clamped = (div_i < W'(2)) ? W'(2) : div_i;

   // ceil(n_act/2) computed one bit wider so n_act = 2^W-1 cannot overflow.
   assign half = {1'b0, n_act[W-1:1]} + {{W{1'b0}}, n_act[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         n_act <= W'(RESET_DIV);
         q_p   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         if (adv) begin
            q_p  <= ({1'b0, cnt} < half);
            tick <= (cnt == '0);
            cnt  <= at_wrap ? '0 : cnt + W'(1);
         end else begin
            cnt  <= '0;
            q_p  <= 1'b0;
            tick <= 1'b0;
         end
         if (load_n) begin
            n_act <= div_clamped;
         end
      end
   end

   // Odd N: q_p is high for (N+1)/2 cycles; ANDing with its negedge copy
   // removes the first half cycle, leaving exactly N/2 cycles high.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_n <= 1'b0;
      end else begin
         q_n <= q_p;
      end
   end

   // The parity select only changes on the wrap edge, where q_p is already
   // low for the final cycle and q_n follows it low, so both paths read 0.
   assign clk_out = n_act[0] ? (q_p & q_n) : q_p;

   assign busy = (cnt != '0) | q_p;

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

   localparam int W         = 8;
   localparam int RESET_DIV = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [W-1:0] div_i;
   logic         clk_out;
   logic         tick;
   logic         busy;
   logic [W-1:0] n_act;

   prog_clk_div #(.W(W), .RESET_DIV(RESET_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .div_i   (div_i),
      .clk_out (clk_out),
      .tick    (tick),
      .busy    (busy),
      .n_act   (n_act)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         clk_out;
      logic         tick;
      logic         busy;
      logic [W-1:0] n_act;
   } obs_t;

   // One segment: optional async reset first, then en/div_i held for some
   // cycles; afterwards the tick count and n_act must match the constants.
   typedef struct {
      logic         pre_rst;
      logic         en;
      logic [W-1:0] div;
      int           cycles;
      int           exp_ticks;
      logic [W-1:0] exp_n;
      string        name;
   } vec_t;

   obs_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   seg_ticks   = 0;

   // Reference model in terms of whole periods.
   bit   m_run = 1'b0;
   int   m_pos = 0;
   int   m_len = 0;
   int   m_n   = RESET_DIV;

   function automatic int clamp_div(input logic [W-1:0] d);
      return (d < 2) ? 2 : int'(d);
   endfunction

   // Half-cycle j of a period of length len: high for len half-cycles,
   // starting half a cycle late when len is odd.
   function automatic logic in_high(input int j, input int len);
      int jr;
      jr = len % 2;
      return (j >= jr) && (j < jr + len);
   endfunction

   function automatic obs_t sample_dut();
      obs_t a;
      a.clk_out = clk_out;
      a.tick    = tick;
      a.busy    = busy;
      a.n_act   = n_act;
      return a;
   endfunction

   task automatic compare(input string tag, input obs_t exp);
      obs_t act;
      act = sample_dut();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got clk_out=%b tick=%b busy=%b n_act=%0d, expected clk_out=%b tick=%b busy=%b n_act=%0d",
                  tag, act.clk_out, act.tick, act.busy, act.n_act,
                  exp.clk_out, exp.tick, exp.busy, exp.n_act);
      end
   endtask

   task automatic check_pop(input string tag);
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         compare(tag, sb.pop_front());
      end
   endtask

   function automatic obs_t idle_obs();
      obs_t o;
      o.clk_out = 1'b0;
      o.tick    = 1'b0;
      o.busy    = 1'b0;
      o.n_act   = W'(RESET_DIV);
      return o;
   endfunction

   // Drive one cycle of stimulus, advance the model, queue the expected
   // post-posedge and post-negedge observations, then check both.
   task automatic step(input logic e, input logic [W-1:0] d, input string tag, input int c);
      obs_t e0;
      obs_t e1;
      logic [W-1:0] nv;
      en    = e;
      div_i = d;
      if (m_run && (m_pos != m_len - 1)) begin
         m_pos++;
         if (m_pos == m_len - 1) m_n = clamp_div(d);
      end else if (e) begin
         m_run = 1'b1;
         m_pos = 0;
         m_len = m_n;
      end else begin
         m_run = 1'b0;
         m_n   = clamp_div(d);
      end
      nv = m_n[W-1:0];
      if (m_run) begin
         e0.clk_out = in_high(2 * m_pos, m_len);
         e0.tick    = (m_pos == 0);
         e0.busy    = (m_pos != m_len - 1);
         e0.n_act   = nv;
         e1         = e0;
         e1.clk_out = in_high(2 * m_pos + 1, m_len);
      end else begin
         e0       = idle_obs();
         e0.n_act = nv;
         e1       = e0;
      end
      sb.push_back(e0);
      sb.push_back(e1);
      @(posedge clk);
      #2;
      check_pop($sformatf("%s c%0d rise", tag, c));
      if (tick) seg_ticks++;
      @(negedge clk);
      #2;
      check_pop($sformatf("%s c%0d fall", tag, c));
   endtask

   // Called at negedge+2 while an N=5 period is in its high phase.
   task automatic reset_mid_period();
      rst_n = 1'b0;
      #1;
      compare("async_rst_drop", idle_obs());
      @(posedge clk);
      #2;
      compare("rst_held", idle_obs());
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      compare("rst_release", idle_obs());
      m_run = 1'b0;
      m_pos = 0;
      m_n   = RESET_DIV;
      sb.delete();
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{1'b0, 1'b0, 8'd4,  2,  0, 8'd4, "idle_load4"});
      tbl.push_back('{1'b0, 1'b1, 8'd4, 24,  6, 8'd4, "run_n4"});
      tbl.push_back('{1'b0, 1'b1, 8'd4,  1,  1, 8'd4, "n4_pos0"});
      tbl.push_back('{1'b0, 1'b1, 8'd7, 10,  1, 8'd7, "chg_4to7"});
      tbl.push_back('{1'b0, 1'b0, 8'd3,  2,  0, 8'd3, "idle_load3"});
      tbl.push_back('{1'b0, 1'b1, 8'd3,  9,  3, 8'd3, "run_n3"});
      tbl.push_back('{1'b0, 1'b0, 8'd6,  1,  0, 8'd6, "idle_load6"});
      tbl.push_back('{1'b0, 1'b1, 8'd6,  1,  1, 8'd6, "n6_start"});
      tbl.push_back('{1'b0, 1'b0, 8'd6,  8,  0, 8'd6, "n6_en_drop"});
      tbl.push_back('{1'b0, 1'b0, 8'd0,  2,  0, 8'd2, "clamp_div0"});
      tbl.push_back('{1'b0, 1'b0, 8'd5,  1,  0, 8'd5, "idle_load5"});
      tbl.push_back('{1'b0, 1'b0, 8'd1,  2,  0, 8'd2, "clamp_div1"});
      tbl.push_back('{1'b0, 1'b1, 8'd1,  6,  3, 8'd2, "run_n2"});
      tbl.push_back('{1'b0, 1'b0, 8'd5,  1,  0, 8'd5, "idle_load5b"});
      tbl.push_back('{1'b0, 1'b1, 8'd5,  2,  1, 8'd5, "n5_high"});
      tbl.push_back('{1'b1, 1'b1, 8'd5,  6,  2, 8'd5, "restart"});
      tbl.push_back('{1'b0, 1'b0, 8'd5,  6,  0, 8'd5, "drain"});

      rst_n = 1'b0;
      en    = 1'b0;
      div_i = '0;
      repeat (2) @(posedge clk);
      #2;
      compare("in_reset", idle_obs());
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      compare("after_reset", idle_obs());

      foreach (tbl[i]) begin
         if (tbl[i].pre_rst) reset_mid_period();
         seg_ticks = 0;
         for (int c = 0; c < tbl[i].cycles; c++) begin
            step(tbl[i].en, tbl[i].div, tbl[i].name, c);
         end
         vectors++;
         if (seg_ticks != tbl[i].exp_ticks) begin
            miscompares++;
            $display("FAIL %s tick_count: got %0d, expected %0d", tbl[i].name, seg_ticks, tbl[i].exp_ticks);
         end
         vectors++;
         if (n_act !== tbl[i].exp_n) begin
            miscompares++;
            $display("FAIL %s n_act_end: got %0d, expected %0d", tbl[i].name, n_act, tbl[i].exp_n);
         end
      end

      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
